// File: rtl/eth_rx_dispatcher.sv
// Packet-granular RX demux: steers each whole Avalon-ST packet from the MAC to one
// NIC, selected by dst-MAC byte 5, through a single registered output stage.
module eth_rx_dispatcher #(
  parameter int          NUM_NICS     = 3,
  parameter logic [7:0]  NIC_MAC_BASE = 8'h00,
  parameter int          DATA_W       = 256
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_valid,
  input  logic                in_sop,
  input  logic                in_eop,
  input  logic [4:0]          in_empty,
  input  logic [5:0]          in_error,
  output logic                in_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_sop,
  output logic                out_eop,
  output logic [4:0]          out_empty,
  output logic [5:0]          out_error,
  output logic [NUM_NICS-1:0] out_valid,
  input  logic [NUM_NICS-1:0] out_ready,
  output logic [31:0]         fwd_count,
  output logic [31:0]         drop_count
);
  localparam int         SEL_W = (NUM_NICS > 1) ? $clog2(NUM_NICS) : 1;
  localparam logic [7:0] NICS8 = 8'(NUM_NICS);

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
    logic [4:0]        empty;
    logic [5:0]        error;
  } beat_t;

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  beat_t               beat_q, beat_d;
  logic [NUM_NICS-1:0] vld_q, vld_d;
  logic [31:0]         fwd_q, fwd_d, drop_q, drop_d;

  logic       held, drain, acc, mapped, load, load_sop;
  logic [7:0] idx;

  // vld_q is one-hot on sel_q, so the reduction only ever sees the selected NIC.
  assign held     = |(vld_q & ~out_ready);
  assign drain    = |(vld_q & out_ready);
  assign in_ready = (state_q == DROP) | ~held;
  assign acc      = in_valid & in_ready;
  assign idx      = in_data[215:208] - NIC_MAC_BASE;
  assign mapped   = idx < NICS8;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    beat_d   = beat_q;
    vld_d    = drain ? '0 : vld_q;
    fwd_d    = fwd_q;
    drop_d   = drop_q;
    load     = 1'b0;
    load_sop = 1'b0;
    case (state_q)
      IDLE: if (acc) begin
        if (in_sop && mapped) begin
          sel_d    = idx[SEL_W-1:0];
          load     = 1'b1;
          load_sop = 1'b1;
          if (in_eop) fwd_d = fwd_q + 32'd1;
          else        state_d = FWD;
        end else begin
          // Unmapped sop and orphan beats share the discard path.
          if (in_eop) drop_d = drop_q + 32'd1;
          else        state_d = DROP;
        end
      end
      FWD: if (acc) begin
        load = 1'b1;
        if (in_eop) begin
          fwd_d   = fwd_q + 32'd1;
          state_d = IDLE;
        end
      end
      DROP: if (acc && in_eop) begin
        drop_d  = drop_q + 32'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      beat_d = '{data: in_data, sop: load_sop, eop: in_eop,
                 empty: in_empty, error: in_error};
      for (int i = 0; i < NUM_NICS; i++) vld_d[i] = (sel_d == SEL_W'(i));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      beat_q  <= '0;
      vld_q   <= '0;
      fwd_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      beat_q  <= beat_d;
      vld_q   <= vld_d;
      fwd_q   <= fwd_d;
      drop_q  <= drop_d;
    end
  end

  assign out_data   = beat_q.data;
  assign out_sop    = beat_q.sop;
  assign out_eop    = beat_q.eop;
  assign out_empty  = beat_q.empty;
  assign out_error  = beat_q.error;
  assign out_valid  = vld_q;
  assign fwd_count  = fwd_q;
  assign drop_count = drop_q;
endmodule

// File: tb/tb_eth_rx_dispatcher.sv
// Directed bench for eth_rx_dispatcher: per-cycle vector table plus a mid-packet reset sequence.
module tb_eth_rx_dispatcher;
  logic         clk = 1'b0;
  logic         reset_n;
  logic [255:0] in_data;
  logic         in_valid, in_sop, in_eop;
  logic [4:0]   in_empty;
  logic [5:0]   in_error;
  logic         in_ready;
  logic [255:0] out_data;
  logic         out_sop, out_eop;
  logic [4:0]   out_empty;
  logic [5:0]   out_error;
  logic [2:0]   out_valid;
  logic [2:0]   out_ready;
  logic [31:0]  fwd_count, drop_count;

  int nerr = 0;
  int nchk = 0;

  eth_rx_dispatcher #(.NUM_NICS(3), .NIC_MAC_BASE(8'h00), .DATA_W(256)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_empty(in_empty), .in_error(in_error), .in_ready(in_ready),
    .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
    .out_empty(out_empty), .out_error(out_error),
    .out_valid(out_valid), .out_ready(out_ready),
    .fwd_count(fwd_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // One row = inputs for one cycle, in_ready expected in that cycle, and
  // the output register / counters expected right after its clock edge.
  typedef struct {
    logic       v, s, e;
    logic [7:0] b5, tag;
    logic [4:0] emp;
    logic [2:0] ordy;
    logic       xrdy;
    logic [2:0] xov;
    logic       xs, xe;
    logic [7:0] xtag;
    logic [4:0] xemp;
    int         xfwd, xdrop;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic s, logic e, logic [7:0] b5, logic [7:0] tag,
                              logic [4:0] emp, logic [2:0] ordy, logic xrdy, logic [2:0] xov,
                              logic xs, logic xe, logic [7:0] xtag, logic [4:0] xemp,
                              int xfwd, int xdrop);
    vec_t r;
    r.v = v; r.s = s; r.e = e; r.b5 = b5; r.tag = tag; r.emp = emp; r.ordy = ordy;
    r.xrdy = xrdy; r.xov = xov; r.xs = xs; r.xe = xe; r.xtag = xtag; r.xemp = xemp;
    r.xfwd = xfwd; r.xdrop = xdrop;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input string id, input vec_t r);
    @(negedge clk);
    in_valid  = r.v;
    in_sop    = r.s;
    in_eop    = r.e;
    in_empty  = r.emp;
    in_data   = '0;
    in_data[255:248] = r.tag;
    in_data[215:208] = r.b5;
    in_error  = r.tag[5:0];
    out_ready = r.ordy;
    #1;
    chk({id, " in_ready"}, {31'd0, in_ready}, {31'd0, r.xrdy});
    @(posedge clk);
    #1;
    chk({id, " out_valid"}, {29'd0, out_valid}, {29'd0, r.xov});
    if (r.xov != 3'b000) begin
      chk({id, " out_sop"},   {31'd0, out_sop},   {31'd0, r.xs});
      chk({id, " out_eop"},   {31'd0, out_eop},   {31'd0, r.xe});
      chk({id, " out_tag"},   {24'd0, out_data[255:248]}, {24'd0, r.xtag});
      chk({id, " out_empty"}, {27'd0, out_empty}, {27'd0, r.xemp});
      chk({id, " out_error"}, {26'd0, out_error}, {26'd0, r.xtag[5:0]});
    end
    chk({id, " fwd_count"},  fwd_count,  r.xfwd);
    chk({id, " drop_count"}, drop_count, r.xdrop);
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    in_empty = '0; in_error = '0; in_data = '0; out_ready = 3'b111;

    // 3-beat packet to NIC1, empty=5 on eop
    tbl.push_back(mk(1,1,0,8'h01,8'h10,0,3'b111, 1,3'b010,1,0,8'h10,0, 0,0));
    tbl.push_back(mk(1,0,0,8'h01,8'h11,0,3'b111, 1,3'b010,0,0,8'h11,0, 0,0));
    tbl.push_back(mk(1,0,1,8'h01,8'h12,5,3'b111, 1,3'b010,0,1,8'h12,5, 1,0));
    tbl.push_back(mk(0,0,0,8'h00,8'h00,0,3'b111, 1,3'b000,0,0,8'h00,0, 1,0));
    // back-to-back single-beat packets to NIC2 then NIC0
    tbl.push_back(mk(1,1,1,8'h02,8'h20,0,3'b111, 1,3'b100,1,1,8'h20,0, 2,0));
    tbl.push_back(mk(1,1,1,8'h00,8'h21,0,3'b111, 1,3'b001,1,1,8'h21,0, 3,0));
    tbl.push_back(mk(0,0,0,8'h00,8'h00,0,3'b111, 1,3'b000,0,0,8'h00,0, 3,0));
    // unmapped 4-beat packet with a stray sop inside, then a good packet
    tbl.push_back(mk(1,1,0,8'h07,8'h30,0,3'b111, 1,3'b000,0,0,8'h00,0, 3,0));
    tbl.push_back(mk(1,0,0,8'h07,8'h31,0,3'b000, 1,3'b000,0,0,8'h00,0, 3,0));
    tbl.push_back(mk(1,1,0,8'h01,8'h32,0,3'b111, 1,3'b000,0,0,8'h00,0, 3,0));
    tbl.push_back(mk(1,0,1,8'h07,8'h33,0,3'b111, 1,3'b000,0,0,8'h00,0, 3,1));
    tbl.push_back(mk(1,1,1,8'h01,8'h34,0,3'b111, 1,3'b010,1,1,8'h34,0, 4,1));
    // 4-beat packet to NIC1 with backpressure from NIC1
    tbl.push_back(mk(1,1,0,8'h01,8'h40,0,3'b111, 1,3'b010,1,0,8'h40,0, 4,1));
    tbl.push_back(mk(1,0,0,8'h01,8'h41,0,3'b101, 0,3'b010,1,0,8'h40,0, 4,1));
    tbl.push_back(mk(1,0,0,8'h01,8'h41,0,3'b101, 0,3'b010,1,0,8'h40,0, 4,1));
    tbl.push_back(mk(1,0,0,8'h01,8'h41,0,3'b111, 1,3'b010,0,0,8'h41,0, 4,1));
    tbl.push_back(mk(1,0,0,8'h01,8'h42,0,3'b101, 0,3'b010,0,0,8'h41,0, 4,1));
    tbl.push_back(mk(1,0,0,8'h01,8'h42,0,3'b010, 1,3'b010,0,0,8'h42,0, 4,1));
    tbl.push_back(mk(1,0,1,8'h01,8'h43,3,3'b111, 1,3'b010,0,1,8'h43,3, 5,1));
    tbl.push_back(mk(0,0,0,8'h00,8'h00,0,3'b111, 1,3'b000,0,0,8'h00,0, 5,1));
    // orphan 2-beat packet, then good NIC0 packet, then idx==NUM_NICS and 8'hff drops
    tbl.push_back(mk(1,0,0,8'h00,8'h50,0,3'b111, 1,3'b000,0,0,8'h00,0, 5,1));
    tbl.push_back(mk(1,0,1,8'h00,8'h51,0,3'b111, 1,3'b000,0,0,8'h00,0, 5,2));
    tbl.push_back(mk(1,1,1,8'h00,8'h52,0,3'b111, 1,3'b001,1,1,8'h52,0, 6,2));
    tbl.push_back(mk(1,1,1,8'h03,8'h53,0,3'b111, 1,3'b000,0,0,8'h00,0, 6,3));
    tbl.push_back(mk(1,1,1,8'hff,8'h54,0,3'b111, 1,3'b000,0,0,8'h00,0, 6,4));

    #2;
    chk("rst out_valid",  {29'd0, out_valid}, 32'd0);
    chk("rst out_data",   out_data[255:224], 32'd0);
    chk("rst out_sop",    {31'd0, out_sop}, 32'd0);
    chk("rst fwd_count",  fwd_count, 32'd0);
    chk("rst drop_count", drop_count, 32'd0);
    chk("rst in_ready",   {31'd0, in_ready}, 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) step($sformatf("row%0d", i), tbl[i]);

    // reset asserted after two beats of a NIC1 packet
    step("h0", mk(1,1,0,8'h01,8'h60,0,3'b111, 1,3'b010,1,0,8'h60,0, 6,4));
    step("h1", mk(1,0,0,8'h01,8'h61,0,3'b111, 1,3'b010,0,0,8'h61,0, 6,4));
    @(negedge clk);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    chk("midrst out_valid",  {29'd0, out_valid}, 32'd0);
    chk("midrst fwd_count",  fwd_count, 32'd0);
    chk("midrst drop_count", drop_count, 32'd0);
    chk("midrst out_tag",    {24'd0, out_data[255:248]}, 32'd0);
    chk("midrst in_ready",   {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    step("h2", mk(1,0,0,8'h01,8'h62,0,3'b111, 1,3'b000,0,0,8'h00,0, 0,0));
    step("h3", mk(1,0,1,8'h01,8'h63,0,3'b111, 1,3'b000,0,0,8'h00,0, 0,1));
    step("h4", mk(1,1,1,8'h02,8'h64,0,3'b111, 1,3'b100,1,1,8'h64,0, 1,1));
    step("h5", mk(0,0,0,8'h00,8'h00,0,3'b111, 1,3'b000,0,0,8'h00,0, 1,1));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
